// File: rtl/enemy_ctrl_pkg.sv
// enemy_ctrl_pkg: state encodings, index width and movement directions shared by the enemy control and enemy logic
package enemy_ctrl_pkg;
   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_GEN   = 3'd2,
      ST_COLL  = 3'd3,
      ST_APPLY = 3'd4,
      ST_DRAW  = 3'd5,
      ST_GAP   = 3'd6,
      ST_DONE  = 3'd7
   } state_e;
   localparam int IDX_W = 2;
   typedef enum logic [2:0] {NO_ACTION, UP, DOWN, LEFT, RIGHT} dir_e;
endpackage

// File: rtl/enemy_control_draw_sequencer.sv
// draw_sequencer: walks the enemies one at a time, asserting draw until draw_done or timeout, with a dead GAP cycle between
module draw_sequencer
   import enemy_ctrl_pkg::*;
#(
   parameter int NUM_ENEMIES  = 2,
   parameter int DRAW_TIMEOUT = 512
) (
   input  logic                   clock_i,
   input  logic                   reset_ni,
   input  logic                   go_i,
   input  logic [NUM_ENEMIES-1:0] draw_done_i,
   output logic [NUM_ENEMIES-1:0] draw_o,
   output logic                   gap_o,
   output logic                   seq_done_o,
   output logic                   timeout_o
);
   localparam int TW = DRAW_TIMEOUT > 2 ? $clog2(DRAW_TIMEOUT) : 1;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   gap_q, gap_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic [NUM_ENEMIES-1:0] sel;
   logic                   hit, last, expired;
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         idx_q  <= '0;
         gap_q  <= 1'b0;
         tcnt_q <= '0;
      end else begin
         idx_q  <= idx_d;
         gap_q  <= gap_d;
         tcnt_q <= tcnt_d;
      end
   end
   // draw_done is only looked at for the selected enemy and never during GAP
   always_comb begin
      sel        = NUM_ENEMIES'(1) << idx_q;
      hit        = |(draw_done_i & sel);
      expired    = tcnt_q == TW'(DRAW_TIMEOUT - 1);
      last       = idx_q == IDX_W'(NUM_ENEMIES - 1);
      timeout_o  = go_i & ~gap_q & ~hit & expired;
      seq_done_o = go_i & gap_q & last;
      gap_o      = go_i & gap_q;
      draw_o     = go_i & ~gap_q ? sel : '0;
      gap_d      = go_i & ~gap_q & (hit | expired);
      idx_d      = ~go_i | seq_done_o ? '0 : gap_q ? idx_q + 1'b1 : idx_q;
      tcnt_d     = ~go_i | gap_q ? '0 : expired ? tcnt_q : tcnt_q + 1'b1;
   end
endmodule

// File: rtl/enemy_control.sv
// enemy_control: paces enemy moves to the frame tick and serialises per-enemy drawing onto the shared write path
module enemy_control
   import enemy_ctrl_pkg::*;
#(
   parameter int NUM_ENEMIES  = 2,
   parameter int MOVE_DIV     = 2,
   parameter int COLL_WAIT    = 2,
   parameter int DRAW_TIMEOUT = 512
) (
   input  logic                   clock_i,
   input  logic                   reset_ni,
   input  logic                   start_i,
   input  logic                   enable_i,
   input  logic                   frame_tick_i,
   input  logic [NUM_ENEMIES-1:0] draw_done_i,
   output logic                   init_o,
   output logic                   idle_o,
   output logic                   gen_move_o,
   output logic                   apply_move_o,
   output logic [NUM_ENEMIES-1:0] draw_o,
   output logic                   frame_done_o,
   output logic                   timeout_err_o,
   output logic                   frame_overrun_o,
   output logic [2:0]             state_dbg_o
);
   state_e     state_q, state_d;
   logic [3:0] fcnt_q, fcnt_d;
   logic [2:0] coll_q, coll_d;
   logic       pend_q, pend_d, terr_q, terr_d, ovr_q, ovr_d;
   logic       leave, seq_gap, seq_done, seq_to;
   draw_sequencer #(.NUM_ENEMIES(NUM_ENEMIES), .DRAW_TIMEOUT(DRAW_TIMEOUT)) u_seq (
      .clock_i    (clock_i),
      .reset_ni   (reset_ni),
      .go_i       (state_q == ST_DRAW),
      .draw_done_i(draw_done_i),
      .draw_o     (draw_o),
      .gap_o      (seq_gap),
      .seq_done_o (seq_done),
      .timeout_o  (seq_to)
   );
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= ST_INIT;
         fcnt_q  <= '0;
         coll_q  <= '0;
         pend_q  <= 1'b0;
         terr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         coll_q  <= coll_d;
         pend_q  <= pend_d;
         terr_q  <= terr_d;
         ovr_q   <= ovr_d;
      end
   end
   // a tick seen outside IDLE is remembered once; a second one is an overrun and is dropped
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      coll_d  = '0;
      pend_d  = pend_q | frame_tick_i;
      terr_d  = terr_q | seq_to;
      ovr_d   = ovr_q | (frame_tick_i & pend_q & (state_q != ST_IDLE));
      leave   = (frame_tick_i | pend_q) & enable_i;
      case (state_q)
         ST_INIT:  state_d = start_i ? ST_IDLE : ST_INIT;
         ST_IDLE: begin
            if (leave) begin
               pend_d  = 1'b0;
               state_d = fcnt_q == 4'(MOVE_DIV - 1) ? ST_GEN : ST_DRAW;
               fcnt_d  = fcnt_q == 4'(MOVE_DIV - 1) ? '0 : fcnt_q + 4'd1;
            end
         end
         ST_GEN:   state_d = ST_COLL;
         ST_COLL: begin
            coll_d  = coll_q + 3'd1;
            state_d = coll_q == 3'(COLL_WAIT - 1) ? ST_APPLY : ST_COLL;
         end
         ST_APPLY: state_d = ST_DRAW;
         ST_DRAW:  state_d = seq_done ? ST_DONE : ST_DRAW;
         default:  state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      init_o          = state_q == ST_INIT;
      idle_o          = state_q == ST_IDLE;
      gen_move_o      = state_q == ST_GEN;
      apply_move_o    = state_q == ST_APPLY;
      frame_done_o    = state_q == ST_DONE;
      timeout_err_o   = terr_q;
      frame_overrun_o = ovr_q;
      state_dbg_o     = (state_q == ST_DRAW) && seq_gap ? ST_GAP : state_q;
   end
endmodule

// File: tb/tb_enemy_control.sv
// tb_enemy_control: random ticks, enable and enemy latencies checked cycle by cycle against a frame-level expected trace
module tb_enemy_control;
   localparam int NE = 2, MD = 2, CW = 2, TO = 16;
   localparam int S_INIT = 0, S_IDLE = 1, S_GEN = 2, S_COLL = 3, S_APPLY = 4, S_DRAW = 5, S_GAP = 6, S_DONE = 7;
   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, enable = 1'b0, tick = 1'b0;
   logic [NE-1:0] done = '0;
   logic          init, idle, gen, apply, fdone, terr, ovr;
   logic [NE-1:0] draw;
   logic [2:0]    state_dbg;
   typedef struct {int st; logic [NE-1:0] dr; bit terr;} ent_t;
   ent_t q[$];
   int   tests = 0, fails = 0;
   int   fcnt, tick_cd, gap_lo, gap_hi, en_flip;
   int   lat[NE], k[NE];
   bit   pend, e_terr, e_ovr, run;

   enemy_control #(.NUM_ENEMIES(NE), .MOVE_DIV(MD), .COLL_WAIT(CW), .DRAW_TIMEOUT(TO)) dut (
      .clock_i        (clk),
      .reset_ni       (rst_n),
      .start_i        (start),
      .enable_i       (enable),
      .frame_tick_i   (tick),
      .draw_done_i    (done),
      .init_o         (init),
      .idle_o         (idle),
      .gen_move_o     (gen),
      .apply_move_o   (apply),
      .draw_o         (draw),
      .frame_done_o   (fdone),
      .timeout_err_o  (terr),
      .frame_overrun_o(ovr),
      .state_dbg_o    (state_dbg)
   );

   always #5 clk = ~clk;

   function automatic ent_t mk(input int st, input logic [NE-1:0] dr, input bit te);
      ent_t e;
      e.st = st; e.dr = dr; e.terr = te;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one frame: optional move (GEN, COLL_WAIT idle cycles, APPLY), each enemy drawn then a GAP, then DONE
   task automatic build();
      bit mv = fcnt == MD - 1;
      fcnt = mv ? 0 : fcnt + 1;
      if (mv) begin
         q.push_back(mk(S_GEN, '0, 0));
         repeat (CW) q.push_back(mk(S_COLL, '0, 0));
         q.push_back(mk(S_APPLY, '0, 0));
      end
      for (int i = 0; i < NE; i++) begin
         logic [NE-1:0] oh = NE'(1) << i;
         lat[i] = $urandom_range(20, 1);
         repeat (lat[i] < TO ? lat[i] : TO) q.push_back(mk(S_DRAW, oh, 0));
         q.push_back(mk(S_GAP, '0, lat[i] > TO));
      end
      q.push_back(mk(S_DONE, '0, 0));
   endtask

   task automatic cycle();
      ent_t e;
      bit   idle_now;
      @(negedge clk);
      e = q.size() != 0 ? q.pop_front() : mk(S_IDLE, '0, 0);
      if (e.terr) e_terr = 1;
      chk("state_dbg", state_dbg, e.st);
      chk("draw", draw, e.dr);
      chk("init/idle/gen/apply/fdone", {init, idle, gen, apply, fdone},
          {e.st == S_INIT, e.st == S_IDLE, e.st == S_GEN, e.st == S_APPLY, e.st == S_DONE});
      chk("timeout_err", terr, e_terr);
      chk("frame_overrun", ovr, e_ovr);
      // behavioural enemies: done after lat cycles of draw, noise on unselected bits
      for (int i = 0; i < NE; i++) begin
         k[i]    = draw[i] ? k[i] + 1 : 0;
         done[i] = draw[i] ? (k[i] >= lat[i]) : 1'($urandom);
      end
      tick = 1'b0;
      if (run) begin
         start = 1'($urandom);
         if (tick_cd == 0) begin
            tick    = 1'b1;
            tick_cd = $urandom_range(gap_hi, gap_lo);
         end else tick_cd--;
         if ($urandom_range(99, 0) < en_flip) enable = ~enable;
      end
      idle_now = e.st == S_IDLE;
      if (idle_now && (tick || pend) && enable) begin
         pend = 0;
         build();
      end else if (tick) begin
         if (!idle_now && pend) e_ovr = 1;
         pend = 1;
      end
   endtask

   task automatic model_reset();
      q.delete();
      pend = 0; e_terr = 0; e_ovr = 0; fcnt = 0; run = 0;
      for (int i = 0; i < NE; i++) begin k[i] = 0; lat[i] = 1; end
   endtask

   initial begin
      model_reset();
      #3;
      chk("rst_state", state_dbg, S_INIT);
      chk("rst_init", init, 1);
      chk("rst_draw", draw, 0);
      chk("rst_flags", {terr, ovr, idle, fdone}, 0);
      #9 rst_n = 1'b1;
      repeat (10) begin
         q.push_back(mk(S_INIT, '0, 0));
         cycle();
      end
      start   = 1'b1;
      enable  = 1'b1;
      tick_cd = 3; gap_lo = 45; gap_hi = 90; en_flip = 0;
      run     = 1;
      repeat (1500) cycle();
      gap_lo = 1; gap_hi = 40; en_flip = 3;
      for (int i = 0; i < 300 && draw == '0; i++) cycle();
      chk("reach_draw", |draw, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_draw", draw, 0);
      chk("arst_init", init, 1);
      chk("arst_state", state_dbg, S_INIT);
      chk("arst_sticky", {terr, ovr}, 0);
      model_reset();
      start = 1'b0; tick = 1'b0; done = '0; enable = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      q.push_back(mk(S_INIT, '0, 0));
      cycle();
      start   = 1'b1;
      tick_cd = 0;
      run     = 1;
      repeat (1500) cycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
